alu_unit_dispatcher: RTL and testbench
======================================

# alu_unit_dispatcher

Parametrised, sequential successor to the ALU function-select decoder. Accepts an operation with a unit-select field over a valid/ready handshake and drives a registered one-hot enable to one of `NUM_UNITS` ALU function units (arithmetic, logic, compare, shift, and later additions). It holds that enable until the selected unit signals completion, or until a timeout expires. Sits between the ALU operand/opcode register stage and the function-unit bank.

## Interface

Reset is synchronous and active-high. The design uses a single clock, `CLK`, with reset `RST`.

Parameters:
- `NUM_UNITS`, default 4: number of function units; range 2..16.
- `SEL_W`, default 2: width of the select field; `2**SEL_W >= NUM_UNITS` is required.
- `TIMEOUT`, default 15: maximum number of cycles an enable stays high without `Unit_Done`; range 1..255.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ALU_FUN_SEL` in `SEL_W`: unit select, i.e. the upper field of `ALU_FUN`.
- `Op_Valid` in 1: operation request.
- `Op_Ready` out 1: dispatcher can accept an operation.
- `Unit_Enable` out `NUM_UNITS`: registered one-hot enable; bit i selects unit i.
- `Unit_Done` in `NUM_UNITS`: per-unit completion strobe.
- `Dispatch_Done` out 1: one-cycle pulse on normal completion.
- `Dispatch_Err` out 1: one-cycle pulse on error.
- `Err_Code` out 2: `00` none, `01` bad select, `10` timeout.
- `Busy` out 1: high while an enable is active.

## Operation

- **FSM states:** `IDLE` and `ACTIVE`.
- **`IDLE`:**
  - `Op_Ready`=1, `Unit_Enable`=0.
  - Accept happens when `Op_Valid` && `Op_Ready`.
  - If `ALU_FUN_SEL` < `NUM_UNITS`: latch the select, set `Unit_Enable[sel]`=1, clear the timeout counter, go to `ACTIVE`.
  - If `ALU_FUN_SEL` >= `NUM_UNITS`: stay in `IDLE`, pulse `Dispatch_Err` with `Err_Code`=`01`. No enable is raised.
- **`ACTIVE`:**
  - `Op_Ready`=0, `Busy`=1, `Unit_Enable` holds its one-hot value.
  - Only `Unit_Done[latched sel]` is observed. Done bits from other units, and any `Unit_Done` while in `IDLE`, are ignored.
  - On `Unit_Done[sel]`: clear `Unit_Enable`, pulse `Dispatch_Done`, go to `IDLE`.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`-1 without done: clear `Unit_Enable`, pulse `Dispatch_Err` with `Err_Code`=`10`, go to `IDLE`.
  - If done and the timeout occur in the same cycle, done wins and no error is raised.
- **`Err_Code`:** registered. Holds the last error code until the next error or reset. A successful dispatch does not clear it.
- **Counter width:** `$clog2(TIMEOUT+1)` bits. The counter does not wrap in normal operation because it is cleared on every accept.
- **`Op_Valid` while `ACTIVE`:** stalls (`Op_Ready`=0). The requester must hold `Op_Valid` and `ALU_FUN_SEL` stable until accepted.
- **Reset values:**
  - state `IDLE`
  - `Unit_Enable`=0
  - `Dispatch_Done`=0
  - `Dispatch_Err`=0
  - `Err_Code`=`00`
  - `Busy`=0
  - counter 0
  - `Op_Ready`=1 from the first cycle after reset
- **Reset mid-`ACTIVE`:** `Unit_Enable` drops at that edge, no done or error pulse is generated, and the in-flight operation is discarded.

## Timing

- `Op_Ready` is combinational from state: `state==IDLE`. All other outputs are registered.
- **Accept at edge k:** `Unit_Enable` and `Busy` are high from k+1.
- **`Unit_Done[sel]` sampled high at edge m:** `Unit_Enable`=0 and `Dispatch_Done`=1 during cycle m+1, and `Op_Ready`=1 in cycle m+1.
- **Minimum enable width:** 1 cycle, when done is high in the first enabled cycle.
- **Issue rate:** the next accept can happen at edge m+1, so back-to-back operations need one idle cycle between enables.
- **Timeout:** the enable is high for exactly `TIMEOUT` cycles. `Dispatch_Err` is asserted in the cycle after the last enabled cycle.
- **Bad select accepted at edge k:** `Dispatch_Err`=1 and `Err_Code`=`01` during cycle k+1. `Op_Ready` stays 1, so a new accept is possible at edge k+1.

## Structure

- Package `alu_dispatch_pkg` contains:
  - the state enum (`IDLE`, `ACTIVE`)
  - the error-code constants `ERR_NONE`, `ERR_SEL`, `ERR_TIMEOUT`
  - a `onehot(sel)` function sized by `NUM_UNITS`
- Sub-module `alu_dispatch_timer` contains the clear/increment counter with an expiry flag, parametrised by `TIMEOUT`.
- The FSM, one-hot register and error register live in the top level.

## Test plan

- **Normal dispatch:** `NUM_UNITS`=4, `SEL_W`=2, `TIMEOUT`=15. Accept `sel`=2, raise `Unit_Done[2]` at the third enabled cycle. Expect `Unit_Enable`=`0100` for 3 cycles, then a `Dispatch_Done` pulse, then `Op_Ready`=1.
- **Bad select:** `NUM_UNITS`=3, `SEL_W`=2, `sel`=3. Expect `Unit_Enable` to stay 0, a 1-cycle `Dispatch_Err` with `Err_Code`=`01`, and `Busy` to stay 0.
- **Timeout:** `TIMEOUT`=4, `sel`=1, no done. Expect `Unit_Enable`=`0010` for exactly 4 cycles, then `Dispatch_Err` with `Err_Code`=`10`. Separately, raise done exactly on the 4th cycle: expect `Dispatch_Done` and no error.
- **Foreign done:** accept `sel`=0 and pulse `Unit_Done`=`1110`. Expect the enable to stay `0001` and no done pulse. Then `Unit_Done[0]` produces `Dispatch_Done`.
- **Stall and back-to-back:** hold `Op_Valid` through `ACTIVE` with `sel`=3. Expect `Op_Ready`=0 throughout, acceptance in the cycle after `Dispatch_Done`, and exactly one idle cycle between enables.
- **Reset mid-`ACTIVE`:** assert `RST` on the 2nd enabled cycle. Expect all outputs at reset values on the next cycle, no pulses, and `Err_Code`=`00`.

Source files
------------

// File: rtl/alu_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch_pkg
// Description : Shared types, error codes and one-hot helper for the ALU
//               function-unit dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_dispatch_pkg;

    // Largest supported function-unit bank; onehot() is built at this width
    // and narrowed by the caller to its own NUM_UNITS.
    localparam int MAX_UNITS = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SEL     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // One-hot decode of a unit select; caller truncates to NUM_UNITS bits.
    function automatic logic [MAX_UNITS-1:0] onehot(input logic [3:0] sel);
        logic [MAX_UNITS-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_dispatch_timer.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch_timer
// Description : Clear/increment cycle counter that flags the last permitted
//               enabled cycle (count == TIMEOUT-1).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dispatch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Counter: cleared on accept (or reset), advanced once per waiting cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/alu_unit_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit_dispatcher
// Description : Accepts an ALU operation over valid/ready and holds a one-hot
//               enable on the selected function unit until it reports done
//               or a timeout expires. Bad selects and timeouts are reported.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_unit_dispatcher
    import alu_dispatch_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int SEL_W     = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [SEL_W-1:0]     ALU_FUN_SEL,
    input  logic                 Op_Valid,
    output logic                 Op_Ready,
    output logic [NUM_UNITS-1:0] Unit_Enable,
    input  logic [NUM_UNITS-1:0] Unit_Done,
    output logic                 Dispatch_Done,
    output logic                 Dispatch_Err,
    output logic [1:0]           Err_Code,
    output logic                 Busy
);
    localparam logic [SEL_W:0] c_NUM_UNITS = (SEL_W + 1)'(NUM_UNITS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_UNITS-1:0] r_enable;
    logic [NUM_UNITS-1:0] w_enable_nxt;
    logic                 r_ddone;
    logic                 w_ddone_nxt;
    logic                 r_derr;
    logic                 w_derr_nxt;
    logic [1:0]           r_err_code;
    logic [1:0]           w_err_code_nxt;
    logic                 r_busy;
    logic                 w_tmr_clr;
    logic                 w_tmr_inc;
    logic                 w_expired;
    logic                 w_sel_ok;
    logic                 w_hit;

    assign w_sel_ok = ({1'b0, ALU_FUN_SEL} < c_NUM_UNITS);
    // The enable register already encodes the latched select, so masking
    // done with it observes only the active unit.
    assign w_hit    = |(Unit_Done & r_enable);

    alu_dispatch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst     (RST),
        .clr     (w_tmr_clr),
        .inc     (w_tmr_inc),
        .expired (w_expired)
    );

    // Next-state and next-output decode; done takes priority over timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_enable_nxt   = r_enable;
        w_ddone_nxt    = 1'b0;
        w_derr_nxt     = 1'b0;
        w_err_code_nxt = r_err_code;
        w_tmr_clr      = 1'b0;
        w_tmr_inc      = 1'b0;
        case (r_state)
            IDLE: begin
                w_enable_nxt = '0;
                if (Op_Valid) begin
                    if (w_sel_ok) begin
                        w_enable_nxt = NUM_UNITS'(onehot(4'(ALU_FUN_SEL)));
                        w_tmr_clr    = 1'b1;
                        w_state_nxt  = ACTIVE;
                    end else begin
                        w_derr_nxt     = 1'b1;
                        w_err_code_nxt = ERR_SEL;
                    end
                end
            end
            ACTIVE: begin
                if (w_hit) begin
                    w_enable_nxt = '0;
                    w_ddone_nxt  = 1'b1;
                    w_state_nxt  = IDLE;
                end else if (w_expired) begin
                    w_enable_nxt   = '0;
                    w_derr_nxt     = 1'b1;
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = IDLE;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            default: begin
                w_enable_nxt = '0;
                w_state_nxt  = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_enable   <= '0;
            r_ddone    <= 1'b0;
            r_derr     <= 1'b0;
            r_err_code <= ERR_NONE;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_enable   <= w_enable_nxt;
            r_ddone    <= w_ddone_nxt;
            r_derr     <= w_derr_nxt;
            r_err_code <= w_err_code_nxt;
            r_busy     <= (w_state_nxt == ACTIVE);
        end
    end

    assign Op_Ready      = (r_state == IDLE);
    assign Unit_Enable   = r_enable;
    assign Dispatch_Done = r_ddone;
    assign Dispatch_Err  = r_derr;
    assign Err_Code      = r_err_code;
    assign Busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unit_dispatcher
// Description : Directed self-checking bench. Instance A uses the default
//               4-unit / TIMEOUT=15 build, instance B a 3-unit / TIMEOUT=4
//               build for bad-select and timeout cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unit_dispatcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [1:0] sel_a   = '0;
    logic       valid_a = 1'b0;
    logic [3:0] done_a  = '0;
    logic       ready_a, ddone_a, derr_a, busy_a;
    logic [3:0] en_a;
    logic [1:0] code_a;

    logic [1:0] sel_b   = '0;
    logic       valid_b = 1'b0;
    logic [2:0] done_b  = '0;
    logic       ready_b, ddone_b, derr_b, busy_b;
    logic [2:0] en_b;
    logic [1:0] code_b;

    int n_pass  = 0;
    int n_total = 0;
    int n_cyc;

    always #5 clk = ~clk;

    alu_unit_dispatcher #(.NUM_UNITS(4), .SEL_W(2), .TIMEOUT(15)) u_dut_a (
        .CLK(clk), .RST(rst), .ALU_FUN_SEL(sel_a), .Op_Valid(valid_a),
        .Op_Ready(ready_a), .Unit_Enable(en_a), .Unit_Done(done_a),
        .Dispatch_Done(ddone_a), .Dispatch_Err(derr_a), .Err_Code(code_a),
        .Busy(busy_a)
    );

    alu_unit_dispatcher #(.NUM_UNITS(3), .SEL_W(2), .TIMEOUT(4)) u_dut_b (
        .CLK(clk), .RST(rst), .ALU_FUN_SEL(sel_b), .Op_Valid(valid_b),
        .Op_Ready(ready_b), .Unit_Enable(en_b), .Unit_Done(done_b),
        .Dispatch_Done(ddone_b), .Dispatch_Err(derr_b), .Err_Code(code_b),
        .Busy(busy_b)
    );

    // Advance one clock; sample point and input-change point is 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        tick(); tick();
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_en",    32'(en_a),    32'd0);
        chk("rst_busy",  32'(busy_a),  32'd0);
        chk("rst_ddone", 32'(ddone_a), 32'd0);
        chk("rst_derr",  32'(derr_a),  32'd0);
        chk("rst_code",  32'(code_a),  32'd0);
        rst = 1'b0;
        tick();

        // ---------------- normal dispatch, sel=2, done at 3rd cycle ----------------
        valid_a = 1'b1; sel_a = 2'd2;
        tick();
        valid_a = 1'b0;
        chk("norm_en1",    32'(en_a),    32'h4);
        chk("norm_busy1",  32'(busy_a),  32'd1);
        chk("norm_ready1", 32'(ready_a), 32'd0);
        tick();
        chk("norm_en2", 32'(en_a), 32'h4);
        tick();
        chk("norm_en3", 32'(en_a), 32'h4);
        done_a = 4'b0100;
        tick();
        done_a = '0;
        chk("norm_en_off", 32'(en_a),    32'd0);
        chk("norm_ddone",  32'(ddone_a), 32'd1);
        chk("norm_ready",  32'(ready_a), 32'd1);
        chk("norm_busy0",  32'(busy_a),  32'd0);
        tick();
        chk("norm_ddone_pulse", 32'(ddone_a), 32'd0);
        chk("norm_code",        32'(code_a),  32'd0);

        // ---------------- foreign done ----------------
        valid_a = 1'b1; sel_a = 2'd0;
        tick();
        valid_a = 1'b0;
        chk("frgn_en", 32'(en_a), 32'h1);
        done_a = 4'b1110;
        tick();
        done_a = '0;
        chk("frgn_en_hold", 32'(en_a),    32'h1);
        chk("frgn_no_done", 32'(ddone_a), 32'd0);
        done_a = 4'b0001;
        tick();
        done_a = '0;
        chk("frgn_ddone", 32'(ddone_a), 32'd1);
        chk("frgn_en_off", 32'(en_a),   32'd0);
        tick();

        // ---------------- stall and back-to-back, sel=3 ----------------
        valid_a = 1'b1; sel_a = 2'd3;
        tick();
        chk("stall_en1",    32'(en_a),    32'h8);
        chk("stall_ready1", 32'(ready_a), 32'd0);
        tick();
        chk("stall_ready2", 32'(ready_a), 32'd0);
        chk("stall_en2",    32'(en_a),    32'h8);
        done_a = 4'b1000;
        tick();
        done_a = '0;
        chk("b2b_ddone", 32'(ddone_a), 32'd1);
        chk("b2b_idle",  32'(en_a),    32'd0);
        chk("b2b_ready", 32'(ready_a), 32'd1);
        tick();
        valid_a = 1'b0;
        chk("b2b_en_again", 32'(en_a),    32'h8);
        chk("b2b_ready0",   32'(ready_a), 32'd0);
        done_a = 4'b1000;
        tick();
        done_a = '0;
        chk("b2b_ddone2", 32'(ddone_a), 32'd1);
        tick();

        // ---------------- timeout on A (TIMEOUT=15) ----------------
        valid_a = 1'b1; sel_a = 2'd1;
        tick();
        valid_a = 1'b0;
        n_cyc = 0;
        while (en_a == 4'b0010 && n_cyc < 40) begin
            n_cyc++;
            tick();
        end
        chk("to15_width", 32'(n_cyc),  32'd15);
        chk("to15_err",   32'(derr_a), 32'd1);
        chk("to15_code",  32'(code_a), 32'd2);
        chk("to15_en",    32'(en_a),   32'd0);
        tick();
        chk("to15_err_pulse", 32'(derr_a), 32'd0);

        // ---------------- bad select on B (3 units, sel=3) ----------------
        valid_b = 1'b1; sel_b = 2'd3;
        tick();
        valid_b = 1'b0;
        chk("bad_en",    32'(en_b),    32'd0);
        chk("bad_err",   32'(derr_b),  32'd1);
        chk("bad_code",  32'(code_b),  32'd1);
        chk("bad_busy",  32'(busy_b),  32'd0);
        chk("bad_ready", 32'(ready_b), 32'd1);
        tick();
        chk("bad_err_pulse", 32'(derr_b), 32'd0);
        chk("bad_code_hold", 32'(code_b), 32'd1);

        // ---------------- timeout on B (TIMEOUT=4), sel=1 ----------------
        valid_b = 1'b1; sel_b = 2'd1;
        tick();
        valid_b = 1'b0;
        n_cyc = 0;
        while (en_b == 3'b010 && n_cyc < 20) begin
            n_cyc++;
            tick();
        end
        chk("to4_width", 32'(n_cyc),   32'd4);
        chk("to4_err",   32'(derr_b),  32'd1);
        chk("to4_code",  32'(code_b),  32'd2);
        chk("to4_ddone", 32'(ddone_b), 32'd0);
        tick();

        // ---------------- done on the 4th (last) cycle: done wins ----------------
        valid_b = 1'b1; sel_b = 2'd1;
        tick();
        valid_b = 1'b0;
        tick(); tick(); tick();
        chk("edge_en4", 32'(en_b), 32'h2);
        done_b = 3'b010;
        tick();
        done_b = '0;
        chk("edge_ddone", 32'(ddone_b), 32'd1);
        chk("edge_noerr", 32'(derr_b),  32'd0);
        chk("edge_code",  32'(code_b),  32'd2);
        chk("edge_en",    32'(en_b),    32'd0);
        tick();

        // ---------------- reset mid-ACTIVE on A ----------------
        valid_a = 1'b1; sel_a = 2'd2;
        tick();
        valid_a = 1'b0;
        tick();
        chk("rstm_en2", 32'(en_a), 32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm_en",    32'(en_a),    32'd0);
        chk("rstm_busy",  32'(busy_a),  32'd0);
        chk("rstm_ready", 32'(ready_a), 32'd1);
        chk("rstm_ddone", 32'(ddone_a), 32'd0);
        chk("rstm_derr",  32'(derr_a),  32'd0);
        chk("rstm_code",  32'(code_a),  32'd0);
        chk("rstm_code_b", 32'(code_b), 32'd0);
        tick();
        chk("rstm_ddone2", 32'(ddone_a), 32'd0);
        chk("rstm_derr2",  32'(derr_a),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
